// File: rtl/axil_sram.sv
// -----------------------------------------------------------------------------
// axil_sram -- AXI4-Lite slave backed by a word-addressed on-chip memory.
//
// Purpose:
//   Byte-addressed AXI-Lite window of MEMORY_DEPTH words starting at BASE_ADDR.
//   Writes are assembled from independent AW and W holding registers and
//   committed with per-byte strobes. Reads are captured read-first at the AR
//   handshake and returned READ_LATENCY cycles later. Out-of-range accesses
//   answer SLVERR (reads return zero) and never touch memory.
//
// Ports:
//   clk, rst                     single rising-edge clock, synchronous active-high reset
//   s_axil_aw* (addr/prot/valid/ready)  write-address channel
//   s_axil_w*  (data/strb/valid/ready)  write-data channel
//   s_axil_b*  (resp/valid/ready)       write-response channel
//   s_axil_ar* (addr/prot/valid/ready)  read-address channel
//   s_axil_r*  (data/resp/valid/ready)  read-data channel
//   awprot/arprot are accepted but have no effect.
// -----------------------------------------------------------------------------
module axil_sram #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    STRB_WIDTH   = DATA_WIDTH / 8,
    parameter int                    MEMORY_DEPTH = 16384,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = {ADDR_WIDTH{1'b0}},
    parameter int                    READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready
);

    localparam int                  BYTE_SHIFT = $clog2(STRB_WIDTH);
    localparam int                  IDX_W      = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L    = (ADDR_WIDTH + 1)'(MEMORY_DEPTH);
    localparam logic [1:0]          RESP_OKAY  = 2'b00;
    localparam logic [1:0]          RESP_SLV   = 2'b10;

    // An unsupported latency is a configuration mistake, so refuse to build.
    generate
        if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_read_latency
            $error("axil_sram: READ_LATENCY must be in 1..4");
        end
    endgenerate

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_WAIT = 2'd1,
        RD_RESP = 2'd2
    } rd_state_e;

    // In range iff at/after the base and the word index falls inside the array.
    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] word_idx;
        word_idx = (addr - BASE_ADDR) >> BYTE_SHIFT;
        return (addr >= BASE_ADDR) && ({1'b0, word_idx} < DEPTH_L);
    endfunction

    // Word index inside the array; sub-word address bits are dropped.
    function automatic logic [IDX_W-1:0] addr_to_idx(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] word_idx;
        word_idx = (addr - BASE_ADDR) >> BYTE_SHIFT;
        return word_idx[IDX_W-1:0];
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [MEMORY_DEPTH];

    logic                  aw_full_q, aw_full_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic                  w_full_q,  w_full_d;
    logic [DATA_WIDTH-1:0] w_data_q,  w_data_d;
    logic [STRB_WIDTH-1:0] w_strb_q,  w_strb_d;
    logic                  bvalid_q,  bvalid_d;
    logic [1:0]            bresp_q,   bresp_d;
    logic                  commit_s;
    logic                  wr_ok_s;
    logic [IDX_W-1:0]      wr_idx_s;

    rd_state_e             rd_state_q, rd_state_d;
    logic [1:0]            rd_cnt_q,   rd_cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q,    rdata_d;
    logic [1:0]            rresp_q,    rresp_d;
    logic                  rd_ok_s;
    logic [IDX_W-1:0]      rd_idx_s;

    logic                  unused_prot_s;
    assign unused_prot_s = ^{s_axil_awprot, s_axil_arprot};

    // Write path: holding-register fill, commit and response handshake.
    always_comb begin
        aw_full_d = aw_full_q;
        aw_addr_d = aw_addr_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        // A pending response blocks the next commit so B stays stable.
        commit_s  = aw_full_q && w_full_q && !bvalid_q;
        wr_ok_s   = addr_in_range(aw_addr_q);
        wr_idx_s  = addr_to_idx(aw_addr_q);

        if (s_axil_awvalid && !aw_full_q) begin
            aw_full_d = 1'b1;
            aw_addr_d = s_axil_awaddr;
        end else if (commit_s) begin
            aw_full_d = 1'b0;
        end else begin
            aw_full_d = aw_full_q;
        end

        if (s_axil_wvalid && !w_full_q) begin
            w_full_d = 1'b1;
            w_data_d = s_axil_wdata;
            w_strb_d = s_axil_wstrb;
        end else if (commit_s) begin
            w_full_d = 1'b0;
        end else begin
            w_full_d = w_full_q;
        end

        if (commit_s) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_ok_s ? RESP_OKAY : RESP_SLV;
        end else if (bvalid_q && s_axil_bready) begin
            bvalid_d = 1'b0;
        end else begin
            bvalid_d = bvalid_q;
        end
    end

    // Write-path state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_full_q <= 1'b0;
            aw_addr_q <= {ADDR_WIDTH{1'b0}};
            w_full_q  <= 1'b0;
            w_data_q  <= {DATA_WIDTH{1'b0}};
            w_strb_q  <= {STRB_WIDTH{1'b0}};
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
        end else begin
            aw_full_q <= aw_full_d;
            aw_addr_q <= aw_addr_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    // Memory byte-lane update; contents survive reset, but a commit that
    // coincides with reset is dropped along with the rest of the transaction.
    always_ff @(posedge clk) begin
        if (!rst && commit_s && wr_ok_s) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (w_strb_q[i]) begin
                    mem_q[wr_idx_s][i*8 +: 8] <= w_data_q[i*8 +: 8];
                end
            end
        end
    end

    // Read FSM: capture the word at the AR handshake (old contents, since the
    // array updates non-blocking), count out the latency, then hold the beat.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_cnt_d   = rd_cnt_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rd_ok_s    = addr_in_range(s_axil_araddr);
        rd_idx_s   = addr_to_idx(s_axil_araddr);

        case (rd_state_q)
            RD_IDLE: begin
                if (s_axil_arvalid) begin
                    rdata_d = rd_ok_s ? mem_q[rd_idx_s] : {DATA_WIDTH{1'b0}};
                    rresp_d = rd_ok_s ? RESP_OKAY : RESP_SLV;
                    if (READ_LATENCY <= 1) begin
                        rd_state_d = RD_RESP;
                    end else begin
                        rd_state_d = RD_WAIT;
                        // WAIT lasts READ_LATENCY-1 cycles; count down to zero.
                        rd_cnt_d   = 2'(READ_LATENCY - 2);
                    end
                end else begin
                    rd_state_d = RD_IDLE;
                end
            end
            RD_WAIT: begin
                if (rd_cnt_q == 2'd0) begin
                    rd_state_d = RD_RESP;
                end else begin
                    rd_cnt_d = rd_cnt_q - 2'd1;
                end
            end
            RD_RESP: begin
                if (s_axil_rready) begin
                    rd_state_d = RD_IDLE;
                end else begin
                    rd_state_d = RD_RESP;
                end
            end
            default: begin
                rd_state_d = RD_IDLE;
            end
        endcase
    end

    // Read-path state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= RD_IDLE;
            rd_cnt_q   <= 2'd0;
            rdata_q    <= {DATA_WIDTH{1'b0}};
            rresp_q    <= 2'b00;
        end else begin
            rd_state_q <= rd_state_d;
            rd_cnt_q   <= rd_cnt_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    assign s_axil_awready = !aw_full_q;
    assign s_axil_wready  = !w_full_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = bresp_q;
    assign s_axil_arready = (rd_state_q == RD_IDLE);
    assign s_axil_rvalid  = (rd_state_q == RD_RESP);
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = rresp_q;

endmodule

// File: tb/tb_axil_sram.sv
// -----------------------------------------------------------------------------
// tb_axil_sram -- directed plus randomized bench for axil_sram.
// Four instances (READ_LATENCY 1..4) share the write channel; each has its own
// arvalid/rready. Expected values come from a word-array model of the memory.
// -----------------------------------------------------------------------------
module tb_axil_sram;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] awaddr, wdata, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, wvalid, bready;
    logic [3:0]  wstrb;
    logic [3:0]  arvalid, rready;
    logic [3:0]  awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp [4];
    logic [1:0]  rresp [4];
    logic [31:0] rdata [4];

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [int];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        axil_sram #(.READ_LATENCY(g + 1)) u_dut (
            .clk            (clk),
            .rst            (rst),
            .s_axil_awaddr  (awaddr),
            .s_axil_awprot  (awprot),
            .s_axil_awvalid (awvalid),
            .s_axil_awready (awready[g]),
            .s_axil_wdata   (wdata),
            .s_axil_wstrb   (wstrb),
            .s_axil_wvalid  (wvalid),
            .s_axil_wready  (wready[g]),
            .s_axil_bresp   (bresp[g]),
            .s_axil_bvalid  (bvalid[g]),
            .s_axil_bready  (bready),
            .s_axil_araddr  (araddr),
            .s_axil_arprot  (arprot),
            .s_axil_arvalid (arvalid[g]),
            .s_axil_arready (arready[g]),
            .s_axil_rdata   (rdata[g]),
            .s_axil_rresp   (rresp[g]),
            .s_axil_rvalid  (rvalid[g]),
            .s_axil_rready  (rready[g])
        );
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory model: 64 KiB window at base 0, 4-byte words.
    function automatic logic in_range(input logic [31:0] addr);
        return addr < 32'h0001_0000;
    endfunction

    function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                        input logic [3:0] strb);
        logic [31:0] w;
        int          idx;
        if (in_range(addr)) begin
            idx = int'(addr >> 2);
            w   = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) w[b*8 +: 8] = data[b*8 +: 8];
            end
            ref_mem[idx] = w;
        end
    endfunction

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        bit aw_done = 1'b0, w_done = 1'b0, aw_hs, w_hs;
        int n = 0;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        while (!(aw_done && w_done) && n < 50) begin
            aw_hs = awvalid && awready[0];
            w_hs  = wvalid && wready[0];
            tick(); n++;
            if (aw_hs) begin awvalid = 1'b0; aw_done = 1'b1; end
            if (w_hs)  begin wvalid  = 1'b0; w_done  = 1'b1; end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        check("wr_accept", {62'd0, aw_done, w_done}, 64'd3);
        n = 0;
        while (!bvalid[0] && n < 50) begin tick(); n++; end
        check("wr_bvalid", bvalid[0], 1'b1);
        resp = bresp[0];
        tick();
    endtask

    task automatic axi_read(input int k, input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output int lat);
        int n = 0;
        araddr = addr;
        arvalid[k] = 1'b1;
        while (!arready[k] && n < 50) begin tick(); n++; end
        tick();
        arvalid[k] = 1'b0;
        lat = 1;
        while (!rvalid[k] && lat < 20) begin tick(); lat++; end
        check("rd_rvalid", rvalid[k], 1'b1);
        data = rdata[k];
        resp = rresp[k];
        if (rready[k]) tick();
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [1:0] r;
        axi_write(addr, data, strb, r);
        check("bresp", r, in_range(addr) ? 2'b00 : 2'b10);
        model_write(addr, data, strb);
    endtask

    task automatic do_read(input int k, input logic [31:0] addr);
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        axi_read(k, addr, d, r, lat);
        check("rd_latency", lat, k + 1);
        if (in_range(addr)) begin
            check("rdata", d, ref_mem[int'(addr >> 2)]);
            check("rresp", r, 2'b00);
        end else begin
            check("rdata_oor", d, 32'h0);
            check("rresp_oor", r, 2'b10);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 4) == 0) return 32'h0001_0000 + ($urandom() & 32'h00FF_FFFF);
        return 32'h100 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
    endfunction

    initial begin
        logic [31:0] d1, d2;
        rst = 1'b1; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        arvalid = 4'h0; rready = 4'hF; awprot = 3'd0; arprot = 3'd0;
        awaddr = 32'h0; araddr = 32'h0; wdata = 32'h0; wstrb = 4'h0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state.
        check("rst_awready", awready, 4'hF);
        check("rst_wready",  wready,  4'hF);
        check("rst_arready", arready, 4'hF);
        check("rst_bvalid",  bvalid,  4'h0);
        check("rst_rvalid",  rvalid,  4'h0);
        check("rst_bresp",   bresp[0], 2'b00);
        check("rst_rresp",   rresp[0], 2'b00);
        check("rst_rdata",   rdata[0], 32'h0);

        // Write then read, AW/W same cycle, minimum B latency, all read latencies.
        awaddr = 32'h10; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check("b_not_yet", bvalid[0], 1'b0);
        tick();
        check("b_lat", bvalid[0], 1'b1);
        check("b_okay", bresp[0], 2'b00);
        tick();
        check("b_cleared", bvalid[0], 1'b0);
        model_write(32'h10, 32'hDEAD_BEEF, 4'hF);
        for (int k = 0; k < 4; k++) do_read(k, 32'h10);
        check("deadbeef_const", ref_mem[4], 32'hDEAD_BEEF);

        // Byte strobes.
        do_write(32'h20, 32'h1122_3344, 4'hF);
        do_write(32'h20, 32'hAABB_CCDD, 4'b0101);
        do_read(0, 32'h20);
        check("strb_const", ref_mem[8], 32'h11BB_33DD);

        // Out of range: no aliasing onto word 0.
        do_write(32'h0, 32'h0BAD_F00D, 4'hF);
        do_write(32'h0001_0000, 32'h5555_AAAA, 4'hF);
        do_read(0, 32'h0001_0000);
        do_read(0, 32'h0);

        // W ahead of AW, then backpressure on B with a second write queued.
        bready = 1'b0;
        wdata = 32'h6060_6060; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("w_held", wready[0], 1'b0);
        check("aw_free", awready[0], 1'b1);
        repeat (2) tick();
        check("no_commit_wo_aw", bvalid[0], 1'b0);
        awaddr = 32'h60; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        tick();
        check("bp_bvalid", bvalid[0], 1'b1);
        awaddr = 32'h64; wdata = 32'h6464_6464; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_awready", awready[0], 1'b0);
            check("bp_wready",  wready[0],  1'b0);
            check("bp_bvalid_hold", bvalid[0], 1'b1);
            check("bp_bresp_hold",  bresp[0],  2'b00);
            tick();
        end
        bready = 1'b1;
        tick();
        check("bp_b1_done", bvalid[0], 1'b0);
        check("bp_aw_still", awready[0], 1'b0);
        tick();
        check("bp_b2", bvalid[0], 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("bp_single_b", bvalid[0], 1'b0);
            tick();
        end
        model_write(32'h60, 32'h6060_6060, 4'hF);
        model_write(32'h64, 32'h6464_6464, 4'hF);
        do_read(0, 32'h60);
        do_read(0, 32'h64);

        // Read-first hazard: AR handshake on the commit edge.
        do_write(32'h40, 32'h1, 4'hF);
        awaddr = 32'h40; wdata = 32'h2; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 32'h40; arvalid[0] = 1'b1;
        tick();
        arvalid[0] = 1'b0;
        check("rf_rvalid", rvalid[0], 1'b1);
        check("rf_old", rdata[0], 32'h1);
        check("rf_bvalid", bvalid[0], 1'b1);
        tick();
        model_write(32'h40, 32'h2, 4'hF);
        do_read(0, 32'h40);

        // Randomized traffic on the latency-1 instance.
        for (int i = 0; i < 8; i++) do_write(32'h100 + 32'(i * 4), $urandom(), 4'hF);
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 0) do_write(rand_addr(), $urandom(), 4'($urandom_range(0, 15)));
            else                           do_read(0, rand_addr());
        end

        // Reset with a read beat pending and only AW accepted.
        do_write(32'h80, 32'hCAFE_F00D, 4'hF);
        rready[0] = 1'b0;
        araddr = 32'h80; arvalid[0] = 1'b1;
        tick();
        arvalid[0] = 1'b0;
        check("mid_rvalid", rvalid[0], 1'b1);
        awaddr = 32'h84; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("mid_aw_held", awready[0], 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rready[0] = 1'b1;
        check("post_bvalid",  bvalid,  4'h0);
        check("post_rvalid",  rvalid,  4'h0);
        check("post_awready", awready, 4'hF);
        check("post_wready",  wready,  4'hF);
        check("post_arready", arready, 4'hF);
        check("post_rdata",   rdata[0], 32'h0);
        d1 = 32'h8888_1234;
        wdata = d1; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stale_aw_dropped", bvalid[0], 1'b0);
            tick();
        end
        awaddr = 32'h88; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        tick();
        check("post_commit", bvalid[0], 1'b1);
        tick();
        model_write(32'h88, d1, 4'hF);
        d2 = ref_mem[32];
        do_read(0, 32'h80);
        check("preserved_const", d2, 32'hCAFE_F00D);
        do_read(0, 32'h88);
        do_read(1, 32'h10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
